burst_io_device: RTL

//  Synthesizable, parametrised external I/O device for the DMA/interrupt path. Holds NUM_BLOCKS

---
 rtl/burst_io_device.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/burst_io_device.sv
// burst_io_device: external I/O device model for the DMA/interrupt path.
// It fills NUM_BLOCKS blocks of BURST_WORDS words from a 16-bit Galois LFSR,
// counts down a programmable delay and raises an interrupt. It then serves
// registered block reads by offset until every block has been read, and
// re-arms up to NUM_FIRES times (0 = forever).
module burst_io_device #(
    parameter int          WORD_SIZE   = 16,
    parameter int          BURST_WORDS = 4,
    parameter int          NUM_BLOCKS  = 3,
    parameter int          OFS_W       = 2,
    parameter int          FIRE_CYCLES = 886,
    parameter int          INT_CYCLES  = 10,
    parameter int          NUM_FIRES   = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [OFS_W-1:0]                 offset,
    input  logic                             rd_en,
    input  logic                             int_ack,
    output logic                             interrupt,
    output logic [BURST_WORDS*WORD_SIZE-1:0] data,
    output logic                             data_valid,
    output logic                             offset_err,
    output logic [7:0]                       fire_count
);

    localparam int BUS_W = BURST_WORDS * WORD_SIZE;
    localparam int TOTAL = NUM_BLOCKS * BURST_WORDS;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int POS_W = (BUS_W > 1) ? $clog2(BUS_W) : 1;
    localparam int CNT_W = $clog2(FIRE_CYCLES + 1);
    localparam int INT_W = $clog2(INT_CYCLES + 1);

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        COUNT = 3'd1,
        FIRE  = 3'd2,
        SERVE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [15:0]             lfsr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [INT_W-1:0]        int_cnt_q;
    logic [NUM_BLOCKS-1:0]   mask_q;
    logic [7:0]              fire_count_q;
    logic                    interrupt_q;
    logic [BUS_W-1:0]        data_q;
    logic                    data_valid_q;
    logic                    offset_err_q;

    logic [BUS_W-1:0]        mem [NUM_BLOCKS];

    logic [WORD_SIZE-1:0]    fill_word;
    logic [BLK_W-1:0]        wr_blk;
    logic [POS_W-1:0]        wr_pos;
    logic [BLK_W-1:0]        rd_blk;
    logic                    fill_last;
    logic                    count_last;
    logic                    fire_exit;
    logic                    mask_full;
    logic                    last_fire;
    logic                    rd_ok;
    logic                    rd_in_range;
    logic                    rd_mark;

    // Galois LFSR step, right shift with taps 0xB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Word taken from the LFSR: low WORD_SIZE bits, zero-extended when wider.
    generate
        if (WORD_SIZE > 16) begin : g_word_wide
            assign fill_word = {{(WORD_SIZE-16){1'b0}}, lfsr_q};
        end else if (WORD_SIZE == 16) begin : g_word_exact
            assign fill_word = lfsr_q;
        end else begin : g_word_narrow
            assign fill_word = lfsr_q[WORD_SIZE-1:0];
        end
    endgenerate

    assign wr_blk      = BLK_W'(32'(idx_q) / BURST_WORDS);
    assign wr_pos      = POS_W'((32'(idx_q) % BURST_WORDS) * WORD_SIZE);
    assign rd_blk      = offset[BLK_W-1:0];

    assign fill_last   = (idx_q == IDX_W'(TOTAL - 1));
    assign count_last  = (cnt_q == CNT_W'(FIRE_CYCLES - 1));
    // Ack and timeout in the same cycle both leave FIRE the same way.
    assign fire_exit   = int_ack || (int_cnt_q == INT_W'(INT_CYCLES - 1));
    assign mask_full   = &mask_q;
    assign last_fire   = (NUM_FIRES != 0) && (32'(fire_count_q) == NUM_FIRES);

    assign rd_ok       = rd_en && (state_q != FILL);
    assign rd_in_range = (32'(offset) < NUM_BLOCKS);
    assign rd_mark     = rd_ok && rd_in_range && ((state_q == FIRE) || (state_q == SERVE));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_last)  state_d = COUNT;
            COUNT:   if (count_last) state_d = FIRE;
            FIRE:    if (fire_exit)  state_d = SERVE;
            SERVE:   if (mask_full)  state_d = last_fire ? DONE : FILL;
            DONE:    state_d = DONE;
            default: state_d = FILL;
        endcase
    end

    // Fill pointer, LFSR, delay counters, interrupt and fire count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q       <= LFSR_SEED;
            idx_q        <= '0;
            cnt_q        <= '0;
            int_cnt_q    <= '0;
            fire_count_q <= '0;
            interrupt_q  <= 1'b0;
        end else begin
            interrupt_q <= (state_d == FIRE);
            case (state_q)
                FILL: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    if (fill_last) begin
                        idx_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                COUNT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (count_last) begin
                        int_cnt_q <= '0;
                        if (fire_count_q != 8'hFF) begin
                            fire_count_q <= fire_count_q + 8'd1;
                        end
                    end
                end
                FIRE: begin
                    int_cnt_q <= int_cnt_q + INT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Read mask: cleared when a fresh fill completes, set by in-range reads
    // while the interrupt is pending or being serviced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if ((state_q == FILL) && fill_last) begin
            mask_q <= '0;
        end else if (rd_mark) begin
            mask_q[rd_blk] <= 1'b1;
        end
    end

    // Block storage, written one word per FILL cycle; never reset.
    always_ff @(posedge clk) begin
        if (state_q == FILL) begin
            mem[wr_blk][wr_pos +: WORD_SIZE] <= fill_word;
        end
    end

    // Registered read port: one result per accepted strobe, data held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            offset_err_q <= 1'b0;
        end else begin
            data_valid_q <= rd_ok;
            if (rd_ok) begin
                if (rd_in_range) begin
                    data_q       <= mem[rd_blk];
                    offset_err_q <= 1'b0;
                end else begin
                    data_q       <= '0;
                    offset_err_q <= 1'b1;
                end
            end
        end
    end

    assign interrupt  = interrupt_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign offset_err = offset_err_q;
    assign fire_count = fire_count_q;

endmodule
